// File: rtl/kb_port_pkg.sv
// Shared constants for the keyboard port: register offsets, status/control
// bit positions and the default FIFO depth.
package kb_port_pkg;

  localparam int DEFAULT_DEPTH = 16;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_ERR    = 3;
  localparam int ST_IE     = 4;

  localparam int CTL_IE    = 0;
  localparam int CTL_FLUSH = 1;

  function automatic logic [7:0] pack_status(input logic ie, input logic err,
                                             input logic ovf, input logic full,
                                             input logic nempty);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_IE]     = ie;
    s[ST_ERR]    = err;
    s[ST_OVF]    = ovf;
    s[ST_FULL]   = full;
    s[ST_NEMPTY] = nempty;
    return s;
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Synchronous scan-code FIFO with flush. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; flush beats both.
module kb_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; the count guards every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kb_port.sv
// Z180-facing keyboard port: buffers receiver scan codes, exposes data and
// status/control registers, and drives an active-low interrupt.
module kb_port
  import kb_port_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CODE,
  input  logic       CODE_VALID,
  input  logic       CODE_ERR,
  input  logic       CS,
  input  logic       A0,
  input  logic       R,
  input  logic       W,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       DOE,
  output logic       INT
);

  // CPU strobes are level accesses, not handshakes: an access is live while
  // CS and R/W are low. Reads act once on the trailing edge (first cycle the
  // access is no longer sampled), control writes act once on the leading edge.
  logic rd_data_acc, rd_stat_acc, wr_ctl_acc;
  logic rd_data_hist, rd_stat_hist, wr_ctl_hist;
  logic pop, stat_clr, ctl_wr, flush;
  logic push, err_set, ovf_set;
  logic ie, ovf, err;
  logic [7:0]  head;
  logic [AW:0] count;
  logic        full, empty, nempty;
  logic        unused_di;

  assign rd_data_acc = ~CS & ~R & (A0 == REG_DATA);
  assign rd_stat_acc = ~CS & ~R & (A0 == REG_STAT);
  assign wr_ctl_acc  = ~CS & ~W & (A0 == REG_STAT);

  assign pop      = rd_data_hist & ~rd_data_acc;
  assign stat_clr = rd_stat_hist & ~rd_stat_acc;
  assign ctl_wr   = wr_ctl_acc & ~wr_ctl_hist;
  assign flush    = ctl_wr & DI[CTL_FLUSH];

  assign push    = CODE_VALID & ~CODE_ERR;
  assign err_set = CODE_VALID & CODE_ERR;
  // Flush discards a coincident code outright, so that is not an overflow.
  assign ovf_set = push & full & ~pop & ~flush;
  assign nempty  = (count != '0);

  assign unused_di = ^DI[7:2];

  kb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .din   (CODE),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_hist <= 1'b0;
      rd_stat_hist <= 1'b0;
      wr_ctl_hist  <= 1'b0;
      ie           <= 1'b0;
      ovf          <= 1'b0;
      err          <= 1'b0;
    end else begin
      rd_data_hist <= rd_data_acc;
      rd_stat_hist <= rd_stat_acc;
      wr_ctl_hist  <= wr_ctl_acc;
      if (ctl_wr) ie <= DI[CTL_IE];
      ovf <= ovf_set | (ovf & ~(stat_clr | flush));
      err <= err_set | (err & ~(stat_clr | flush));
    end
  end

  always_comb begin
    DO = 8'h00;
    if (A0 == REG_STAT) DO = pack_status(ie, err, ovf, full, nempty);
    else if (!empty)    DO = head;
  end

  assign DOE = ~CS & ~R;
  assign INT = ~(ie & nempty);

endmodule

// File: tb/tb_kb_port.sv
// Bench for kb_port: directed vector table, hand-written corner sequences and
// a randomized phase checked against a queue-based register model.
module tb_kb_port;

  localparam int DEPTH = 16;
  localparam int OP_PUSH    = 0;
  localparam int OP_PERR    = 1;
  localparam int OP_RD_DATA = 2;
  localparam int OP_RD_STAT = 3;
  localparam int OP_WR_CTL  = 4;
  localparam int OP_WR_DATA = 5;

  logic       clk, rst;
  logic [7:0] code;
  logic       code_valid, code_err;
  logic       cs, a0, r, w;
  logic [7:0] di;
  logic [7:0] do_bus;
  logic       doe, int_n;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic       m_ie, m_ovf, m_err;

  kb_port #(.DEPTH(DEPTH), .AW(4)) dut (
    .CLK(clk), .RST(rst), .CODE(code), .CODE_VALID(code_valid),
    .CODE_ERR(code_err), .CS(cs), .A0(a0), .R(r), .W(w), .DI(di),
    .DO(do_bus), .DOE(doe), .INT(int_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ie  = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  // scoreboard helpers
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {3'b000, m_ie, m_err, m_ovf, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  function automatic logic m_int();
    return ~(m_ie & (exp_q.size() != 0));
  endfunction

  // driver tasks
  task automatic drive_push(input logic [7:0] c, input logic e);
    code = c;
    code_err = e;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    code_err = 1'b0;
  endtask

  task automatic drive_read(input logic sel, input int len, output logic [7:0] act);
    cs = 1'b0;
    a0 = sel;
    r = 1'b0;
    #1;
    act = do_bus;
    check1("doe_during_read", doe, 1'b1);
    repeat (len) tick();
    r = 1'b1;
    cs = 1'b1;
    tick();
  endtask

  task automatic drive_write(input logic sel, input logic [7:0] d, input int len);
    cs = 1'b0;
    a0 = sel;
    w = 1'b0;
    di = d;
    repeat (len) tick();
    w = 1'b1;
    cs = 1'b1;
    tick();
  endtask

  // one bus/receiver transaction, with model update; exp is the model's read value
  task automatic do_op(input int op, input logic [7:0] arg, input int len,
                       output logic [7:0] act, output logic [7:0] exp);
    act = 8'h00;
    exp = 8'h00;
    case (op)
      OP_PUSH: begin
        drive_push(arg, 1'b0);
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(arg);
      end
      OP_PERR: begin
        drive_push(arg, 1'b1);
        m_err = 1'b1;
      end
      OP_RD_DATA: begin
        exp = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        drive_read(1'b0, len, act);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      OP_RD_STAT: begin
        exp = m_status();
        drive_read(1'b1, len, act);
        m_ovf = 1'b0;
        m_err = 1'b0;
      end
      OP_WR_CTL: begin
        drive_write(1'b1, arg, len);
        m_ie = arg[0];
        if (arg[1]) begin
          exp_q.delete();
          m_ovf = 1'b0;
          m_err = 1'b0;
        end
      end
      default: drive_write(1'b0, arg, len);
    endcase
  endtask

  typedef struct {
    int         op;
    logic [7:0] arg;
    logic [7:0] exp_do;
    logic       exp_int;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [7:0] act, exp;

    rst = 1'b0; code = 8'h00; code_valid = 1'b0; code_err = 1'b0;
    cs = 1'b1; a0 = 1'b0; r = 1'b1; w = 1'b1; di = 8'h00;
    model_reset();

    vecs[0]  = '{OP_RD_STAT, 8'h00, 8'h00, 1'b1};
    vecs[1]  = '{OP_RD_DATA, 8'h00, 8'h00, 1'b1};
    vecs[2]  = '{OP_PUSH,    8'h1C, 8'h00, 1'b1};
    vecs[3]  = '{OP_RD_STAT, 8'h00, 8'h01, 1'b1};
    vecs[4]  = '{OP_RD_DATA, 8'h00, 8'h1C, 1'b1};
    vecs[5]  = '{OP_RD_STAT, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{OP_PERR,    8'hAA, 8'h00, 1'b1};
    vecs[7]  = '{OP_RD_STAT, 8'h00, 8'h08, 1'b1};
    vecs[8]  = '{OP_RD_STAT, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{OP_PERR,    8'hAA, 8'h00, 1'b1};
    vecs[10] = '{OP_PUSH,    8'h12, 8'h00, 1'b1};
    vecs[11] = '{OP_RD_STAT, 8'h00, 8'h09, 1'b1};
    vecs[12] = '{OP_RD_DATA, 8'h00, 8'h12, 1'b1};
    vecs[13] = '{OP_WR_CTL,  8'h01, 8'h00, 1'b1};
    vecs[14] = '{OP_PUSH,    8'h5A, 8'h00, 1'b0};
    vecs[15] = '{OP_RD_STAT, 8'h00, 8'h11, 1'b0};
    vecs[16] = '{OP_RD_DATA, 8'h00, 8'h5A, 1'b1};
    vecs[17] = '{OP_RD_STAT, 8'h00, 8'h10, 1'b1};
    vecs[18] = '{OP_WR_CTL,  8'h00, 8'h00, 1'b1};
    vecs[19] = '{OP_RD_STAT, 8'h00, 8'h00, 1'b1};

    // reset state
    tick();
    #1;
    check1("reset_int", int_n, 1'b1);
    check8("reset_do", do_bus, 8'h00);
    rst = 1'b1;
    tick();

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i].op, vecs[i].arg, 1 + (i % 3), act, exp);
      if (vecs[i].op == OP_RD_DATA || vecs[i].op == OP_RD_STAT)
        check8($sformatf("vec%0d_do", i), act, vecs[i].exp_do);
      check1($sformatf("vec%0d_int", i), int_n, vecs[i].exp_int);
    end

    // overflow: 17 pushes into 16 entries
    apply_reset();
    for (int i = 1; i <= 17; i++) do_op(OP_PUSH, 8'(i), 1, act, exp);
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("ovf_status", act, 8'h07);
    for (int i = 1; i <= 16; i++) begin
      do_op(OP_RD_DATA, 8'h00, 1, act, exp);
      check8($sformatf("ovf_data%0d", i), act, 8'(i));
    end
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("ovf_cleared", act, 8'h00);

    // full FIFO: push coincides with the pop edge
    apply_reset();
    for (int i = 0; i < 16; i++) do_op(OP_PUSH, 8'h20 + 8'(i), 1, act, exp);
    cs = 1'b0; a0 = 1'b0; r = 1'b0;
    tick();
    r = 1'b1; cs = 1'b1;
    code = 8'h30; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h30);
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("coincide_status", act, 8'h03);
    for (int i = 0; i < 16; i++) begin
      do_op(OP_RD_DATA, 8'h00, 1, act, exp);
      check8($sformatf("coincide_data%0d", i), act, 8'h21 + 8'(i));
    end

    // reset in the middle of a data read with 3 entries
    apply_reset();
    do_op(OP_WR_CTL, 8'h01, 1, act, exp);
    for (int i = 0; i < 3; i++) do_op(OP_PUSH, 8'h40 + 8'(i), 1, act, exp);
    cs = 1'b0; a0 = 1'b0; r = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    check1("midreset_int", int_n, 1'b1);
    check8("midreset_do", do_bus, 8'h00);
    r = 1'b1; cs = 1'b1;
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("after_reset_status", act, 8'h00);
    check1("after_reset_int", int_n, 1'b1);
    do_op(OP_PUSH, 8'h44, 1, act, exp);
    do_op(OP_RD_DATA, 8'h00, 1, act, exp);
    check8("after_reset_data", act, 8'h44);

    // flush with entries present
    for (int i = 0; i < 3; i++) do_op(OP_PUSH, 8'h50 + 8'(i), 1, act, exp);
    do_op(OP_WR_CTL, 8'h02, 1, act, exp);
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("flush_status", act, 8'h00);

    // held control write flushes once; a later push survives
    do_op(OP_PUSH, 8'h60, 1, act, exp);
    cs = 1'b0; a0 = 1'b1; w = 1'b0; di = 8'h02;
    tick();
    code = 8'h77; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    w = 1'b1; cs = 1'b1;
    tick();
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("held_flush_status", act, 8'h01);
    do_op(OP_RD_DATA, 8'h00, 1, act, exp);
    check8("held_flush_data", act, 8'h77);

    // flush and push in the same cycle: code discarded
    cs = 1'b0; a0 = 1'b1; w = 1'b0; di = 8'h02;
    code = 8'h66; code_valid = 1'b1;
    tick();
    code_valid = 1'b0; w = 1'b1; cs = 1'b1;
    tick();
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("flush_push_status", act, 8'h00);

    // randomized phase against the model
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      int sel, op, len;
      logic [7:0] arg;
      sel = int'($urandom_range(0, 19));
      len = int'($urandom_range(1, 3));
      arg = 8'($urandom_range(0, 255));
      if (sel < 9)       op = OP_PUSH;
      else if (sel < 10) op = OP_PERR;
      else if (sel < 15) op = OP_RD_DATA;
      else if (sel < 17) op = OP_RD_STAT;
      else if (sel < 19) op = OP_WR_CTL;
      else               op = OP_WR_DATA;
      if (op == OP_WR_CTL && $urandom_range(0, 5) != 0) arg[1] = 1'b0;
      do_op(op, arg, len, act, exp);
      if (op == OP_RD_DATA || op == OP_RD_STAT)
        check8($sformatf("rand%0d_do", i), act, exp);
      check1($sformatf("rand%0d_int", i), int_n, m_int());
    end
    do_op(OP_RD_STAT, 8'h00, 1, act, exp);
    check8("rand_final_status", act, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
